// File: rtl/lsu_mem_stage_pkg.sv
// lsu_mem_stage_pkg: funct3 access codes and FSM states for the memory-access stage
package lsu_mem_stage_pkg;
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;
    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;
endpackage

// File: rtl/lsu_mem_stage_lane.sv
// lsu_lane: byte/half lane extraction with extension, store-lane merge, and access legality
module lsu_lane
    import lsu_mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    input  logic            we,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_val,
    output logic [XLEN-1:0] merged,
    output logic            err
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        illegal;
    logic        misaligned;
    always_comb begin
        byte_v = word[{offset, 3'b000} +: 8];
        half_v = word[{offset[1], 4'b0000} +: 16];
        illegal = we ? (funct3 > F3_SW) : (funct3 == 3'd3 || funct3 > F3_LHU);
        misaligned = (funct3[1:0] == 2'd1 && offset[0]) || (funct3[1:0] == 2'd2 && offset != 2'd0);
        err = illegal || misaligned;
        load_val = funct3 == F3_LB  ? {{(XLEN-8){byte_v[7]}}, byte_v} :
                   funct3 == F3_LH  ? {{(XLEN-16){half_v[15]}}, half_v} :
                   funct3 == F3_LBU ? {{(XLEN-8){1'b0}}, byte_v} :
                   funct3 == F3_LHU ? {{(XLEN-16){1'b0}}, half_v} : word;
        merged = word;
        if (funct3 == F3_SB)
            merged[{offset, 3'b000} +: 8] = store_data[7:0];
        else if (funct3 == F3_SH)
            merged[{offset[1], 4'b0000} +: 16] = store_data[15:0];
        else
            merged = store_data;
    end
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store FSM over a 32-bit word RAM with sub-word read-modify-write
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            done_o,
    output logic            err_o,
    output logic            busy_o,
    output logic [XLEN-1:0] ram_addr_o,
    output logic            ram_we_o,
    output logic [XLEN-1:0] ram_data_o,
    input  logic [XLEN-1:0] ram_data_i
);
    state_t          state, state_nxt;
    logic            we_q, err_q, lane_we, lane_err;
    logic [2:0]      funct3_q, lane_f3;
    logic [1:0]      lane_off;
    logic [XLEN-1:0] addr_q, word_q, rdata_q, load_val, merged;
    assign lane_off = state == IDLE ? addr_i[1:0] : addr_q[1:0];
    assign lane_f3  = state == IDLE ? funct3_i : funct3_q;
    assign lane_we  = state == IDLE ? we_i : we_q;
    lsu_lane #(.XLEN(XLEN)) u_lane (
        .word       (ram_data_i),
        .offset     (lane_off),
        .funct3     (lane_f3),
        .we         (lane_we),
        .store_data (word_q),
        .load_val   (load_val),
        .merged     (merged),
        .err        (lane_err)
    );
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_i) state_nxt = lane_err ? DONE : (we_i && funct3_i == F3_SW) ? WRITE : READ;
            READ:    state_nxt = MERGE;
            MERGE:   state_nxt = we_q ? WRITE : DONE;
            WRITE:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end
    // word_q carries the store data until MERGE, then the merged word for WRITE
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
        end else begin
            if (state == IDLE && req_i) begin
                we_q     <= we_i;
                err_q    <= lane_err;
                funct3_q <= funct3_i;
                addr_q   <= addr_i;
                word_q   <= wdata_i;
            end
            if (state == MERGE && we_q)
                word_q <= merged;
            if (state == MERGE && !we_q)
                rdata_q <= load_val;
        end
    end
    assign ram_addr_o = {addr_q[XLEN-1:2], 2'b00};
    assign ram_we_o   = state == WRITE;
    assign ram_data_o = word_q;
    assign rdata_o    = rdata_q;
    assign done_o     = state == DONE;
    assign err_o      = done_o && err_q;
    assign busy_o     = state != IDLE;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: randomized scoreboard bench for lsu_mem_stage against a behavioural word-memory model
module tb_lsu_mem_stage;
    logic        clk = 1'b0, reset = 1'b1, req_i = 1'b0, we_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] addr_i = 32'd0, wdata_i = 32'd0, ram_data_i = 32'd0;
    logic [31:0] rdata_o, ram_addr_o, ram_data_o;
    logic        done_o, err_o, busy_o, ram_we_o;
    logic [31:0] ram [256];
    logic [31:0] mm [256];
    logic [31:0] m_rdata = 32'd0;
    int cyc = 0, vectors = 0, errors = 0, we_cnt = 0;

    typedef struct {
        int          issue;
        int          done_cyc;
        logic        err;
        logic [31:0] rdata;
        logic [7:0]  idx;
        logic [31:0] word;
        int          n_we;
    } exp_t;
    exp_t q[$];

    lsu_mem_stage dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req_i),
        .we_i       (we_i),
        .funct3_i   (funct3_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .busy_o     (busy_o),
        .ram_addr_o (ram_addr_o),
        .ram_we_o   (ram_we_o),
        .ram_data_o (ram_data_o),
        .ram_data_i (ram_data_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        ram_data_i <= ram[ram_addr_o[9:2]];
        if (ram_we_o) ram[ram_addr_o[9:2]] <= ram_data_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic eb;
        if (!reset) begin
            if (ram_we_o) we_cnt++;
            eb = q.size() > 0 ? (cyc > q[0].issue) : 1'b0;
            chk("busy", 32'(busy_o), 32'(eb));
            if (done_o) begin
                if (q.size() == 0) chk("done_with_no_request", 32'(done_o), 32'd0);
                else begin
                    e = q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    chk("err", 32'(err_o), 32'(e.err));
                    chk("rdata", rdata_o, e.rdata);
                    chk("ram_word", ram[e.idx], e.word);
                    chk("we_pulses", 32'(we_cnt), 32'(e.n_we));
                end
                we_cnt = 0;
            end else
                chk("err_without_done", 32'(err_o), 32'd0);
        end else
            we_cnt = 0;
    end

    task automatic wait_idle();
        int t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            chk("timeout_pending", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit poke);
        exp_t e;
        int nb, sh;
        logic [31:0] mask, w, v;
        logic bad;
        wait_idle();
        @(posedge clk); #1;
        nb = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        sh = 8 * int'(addr[1:0]);
        mask = nb == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
        bad = (we ? f3 > 3'd2 : (f3 == 3'd3 || f3 > 3'd5)) || (int'(addr[1:0]) % nb != 0);
        w = mm[addr[9:2]];
        e.issue = cyc;
        e.idx = addr[9:2];
        e.err = bad;
        e.n_we = 0;
        if (bad)
            e.done_cyc = cyc + 1;
        else if (we) begin
            mm[addr[9:2]] = (w & ~(mask << sh)) | ((wd & mask) << sh);
            e.n_we = 1;
            e.done_cyc = cyc + (nb == 4 ? 2 : 4);
        end else begin
            v = (w >> sh) & mask;
            if (f3 < 3'd4 && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
            m_rdata = v;
            e.done_cyc = cyc + 3;
        end
        e.rdata = m_rdata;
        e.word = mm[addr[9:2]];
        q.push_back(e);
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wd;
        @(posedge clk); #1;
        req_i = poke;
        if (poke) begin
            we_i = ~we;
            funct3_i = 3'($urandom_range(0, 7));
            addr_i = $urandom_range(0, 1023);
            wdata_i = $urandom;
        end
        @(posedge clk); #1;
        req_i = 1'b0;
    endtask

    initial begin
        exp_t ph;
        logic [31:0] a;
        logic [2:0] f;
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom;
            mm[i] = ram[i];
        end
        ram[64] = 32'h80FF7F01;
        mm[64] = 32'h80FF7F01;
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h100; wdata_i = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ram_addr", ram_addr_o, 32'd0);
        chk("rst_ram_we", 32'(ram_we_o), 32'd0);
        chk("rst_ram_data", ram_data_o, 32'd0);
        req_i = 1'b0;
        reset = 1'b0;
        issue(1'b0, 3'd0, 32'h101, 32'd0, 1'b0);
        issue(1'b0, 3'd0, 32'h103, 32'd0, 1'b0);
        issue(1'b0, 3'd4, 32'h103, 32'd0, 1'b0);
        issue(1'b0, 3'd1, 32'h102, 32'd0, 1'b0);
        issue(1'b0, 3'd5, 32'h102, 32'd0, 1'b0);
        issue(1'b0, 3'd2, 32'h100, 32'd0, 1'b0);
        issue(1'b1, 3'd0, 32'h101, 32'h0000_00AA, 1'b0);
        issue(1'b1, 3'd1, 32'h102, 32'h0000_1234, 1'b1);
        issue(1'b0, 3'd2, 32'h100, 32'd0, 1'b0);
        issue(1'b1, 3'd2, 32'h204, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 3'd2, 32'h102, 32'd0, 1'b1);
        issue(1'b1, 3'd1, 32'h101, 32'h5555_5555, 1'b0);
        issue(1'b0, 3'd3, 32'h100, 32'd0, 1'b1);
        issue(1'b1, 3'd3, 32'h100, 32'd0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            a = 32'($urandom_range(0, 1023));
            f = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) a[1:0] = f[0] ? {a[1], 1'b0} : 2'b00;
            issue(1'($urandom_range(0, 1)), f, a, $urandom, 1'($urandom_range(0, 1)));
        end
        wait_idle();
        @(posedge clk); #1;
        ph.issue = cyc; ph.done_cyc = 0; ph.err = 1'b0; ph.rdata = 32'd0;
        ph.idx = 8'd64; ph.word = 32'd0; ph.n_we = 0;
        q.push_back(ph);
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'd0; addr_i = 32'h101; wdata_i = 32'h0000_0055;
        @(posedge clk); #1;
        req_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_busy", 32'(busy_o), 32'd0);
        chk("rst_mid_we", 32'(ram_we_o), 32'd0);
        chk("rst_mid_done", 32'(done_o), 32'd0);
        q.delete();
        m_rdata = 32'd0;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_ram_word", ram[64], mm[64]);
        chk("rst_mid_rdata", rdata_o, 32'd0);
        issue(1'b0, 3'd2, 32'h100, 32'd0, 1'b0);
        issue(1'b1, 3'd0, 32'h100, 32'h0000_0077, 1'b0);
        issue(1'b0, 3'd4, 32'h100, 32'd0, 1'b0);
        wait_idle();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
